alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Issue controller between the decode stage and the `alu` execute stage. It decides each cycle whether the decoded instruction is issued to the ALU or a stall bubble is injected. It detects load-use hazards and sequences branch delay slots and fetch redirects, including the `br_trigger` handshake the ALU waits on. It also flushes the front end and holds issue when the ALU reports a trap.

## Interface
Parameters:
- `EXC_W`, default 8: exception code width, matching the ALU `exception` bus.
- `TRAP_STALL`, default from shared defines: bubble code driven on `issue_exception`.
- `TRAP_SLOT`, default from shared defines: code raised for a branch in a delay slot.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `dec_valid` in 1: decode presents an instruction.
- `dec_ready` out 1: instruction accepted this cycle.
- `dec_rs`, `dec_rt` in 5 each: source register indices.
- `dec_uses_rs`, `dec_uses_rt` in 1 each: source is actually read.
- `dec_wr_reg` in 5: destination register; 0 means no write.
- `dec_is_load` in 1: instruction is a load.
- `dec_is_branch` in 1: instruction is a branch or jump (BAL/B*/JAL/JALR).
- `alu_br_enable` in 1: ALU branch-taken output (registered in the ALU).
- `alu_br_target` in 32: ALU branch target.
- `alu_exception` in EXC_W: ALU exception output.
- `issue` out 1: ALU consumes the decoded op this cycle.
- `issue_exception` out EXC_W: drives the ALU `exception_in`; 0 = real op, TRAP_STALL = bubble.
- `br_trigger` out 1: to ALU; new fetch stream is in flight.
- `fetch_redirect` out 1: one-cycle pulse to fetch.
- `fetch_target` out 32: PC for the redirect.
- `flush` out 1: kill instructions held in fetch/decode.
- `trap_taken` out 1: one-cycle pulse when a trap is taken.
- `trap_code` out EXC_W: code of the latched trap.
- `trap_ack` in 1: handler has taken over; release TRAP.

## Operation
- States:
  - RUN: normal issue.
  - DELAY: branch issued; delay slot pending.
  - REDIRECT: one cycle; steer fetch.
  - REFILL: waiting for the first target instruction.
  - TRAP: hold until acknowledged.
- Issue rule, RUN and DELAY: `issue = dec_valid & ~hazard & ~flush`.
  - `dec_ready = issue`.
  - `issue_exception = issue ? 0 : TRAP_STALL`.
- Hazard: true when the last issued op was a load with nonzero `wr_reg`, and that `wr_reg` equals an used `dec_rs`/`dec_rt`. The hazard costs exactly one bubble; load state clears after one cycle.
- RUN → DELAY: when an issued instruction has `dec_is_branch`.
- DELAY:
  - The next issued instruction is the delay slot.
  - If `alu_br_enable` is seen, latch `alu_br_target` and mark the branch taken.
  - After the delay slot issues: taken → REDIRECT; not taken → RUN.
  - A branch in the delay slot is not issued: bubble is issued and the controller goes to TRAP with `trap_code = TRAP_SLOT`.
- REDIRECT:
  - Drive `fetch_redirect = 1`, `fetch_target` = latched target, `flush = 1`, `br_trigger = 1`, bubble.
  - Then go to REFILL.
- REFILL:
  - Hold `br_trigger = 1` and issue normally.
  - Go to RUN on the first issue.
- TRAP:
  - Entered from any state when `alu_exception` is nonzero and not TRAP_STALL.
  - Latch `trap_code`, pulse `trap_taken`, hold `flush = 1`, issue bubbles.
  - Go to RUN on `trap_ack`.
  - Further exceptions while in TRAP are ignored.
- Priority: trap entry > redirect > hazard bubble > issue.

## Timing
- Reset values: state RUN, load tracking cleared, `issue` 0, `dec_ready` 0, `issue_exception` TRAP_STALL, `br_trigger` 0, `fetch_redirect` 0, `fetch_target` 0, `flush` 0, `trap_taken` 0, `trap_code` 0.
- Reset mid-branch or mid-trap discards all latched state immediately.
- `issue`, `dec_ready`, `issue_exception`: combinational from state, hazard and `dec_*`. All other outputs are registered.
- Branch issued at edge N:
  - `alu_br_enable` visible in cycle N+1.
  - Delay slot issues at the earliest cycle ≥ N+1 with `dec_valid`.
  - REDIRECT occupies the cycle after the slot issues.
  - `br_trigger` stays high from REDIRECT until the first REFILL issue.
- Load-use: load at edge N, dependent op held in cycle N+1, issued at edge N+2.
- ALU exception seen in cycle M → `trap_taken` high in M+1, with no issue in M+1.

## Structure
- Shared package/defines: TRAP_* codes, ALU op encodings, state enum (RUN/DELAY/REDIRECT/REFILL/TRAP).
- Sub-module `hazard_detect`: combinational load-use compare against the registered last-load destination.

## Test plan
- Back-to-back ALU_ADD, `dec_valid` held high → `issue` every cycle, `issue_exception` 0, no bubbles.
- Load with `wr_reg` 5, then an op with rs=5 → one TRAP_STALL bubble, issue on the following cycle; with rs=0 or `wr_reg` 0 → no bubble.
- BEQ taken, target 0x100 → delay slot issues; next cycle `fetch_redirect`=1 with `fetch_target`=0x100, `flush`=1; `br_trigger` held until the first target op issues.
- BNE not taken → delay slot issues; no redirect, `br_trigger` stays 0, state back to RUN.
- ALU reports TRAP_OVERFLOW → `trap_taken` pulse, `trap_code`=TRAP_OVERFLOW, bubbles until `trap_ack`, then normal issue.
- Branch in a delay slot → TRAP_SLOT trap. `rst` asserted mid-DELAY → all outputs at reset values asynchronously.

Source files
------------

// File: rtl/alu_issue_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl_pkg
// Shared definitions for the decode-to-ALU issue controller:
//   - exception / trap codes carried on the ALU exception buses
//   - ALU operation encodings used by decode
//   - issue controller state enumeration
// No ports (package).
// -----------------------------------------------------------------------------
package alu_issue_ctrl_pkg;

   // Exception codes (8-bit, matching the default ALU exception bus width).
   localparam logic [7:0] TRAP_NONE       = 8'h00;
   localparam logic [7:0] TRAP_OVERFLOW   = 8'h01;
   localparam logic [7:0] TRAP_ILLEGAL    = 8'h02;
   localparam logic [7:0] TRAP_SLOT_CODE  = 8'h03;
   localparam logic [7:0] TRAP_STALL_CODE = 8'hFF;

   // ALU operation encodings presented by decode.
   typedef enum logic [3:0] {
      ALU_ADD  = 4'h0,
      ALU_SUB  = 4'h1,
      ALU_AND  = 4'h2,
      ALU_OR   = 4'h3,
      ALU_XOR  = 4'h4,
      ALU_SLT  = 4'h5,
      ALU_SLL  = 4'h6,
      ALU_SRL  = 4'h7,
      ALU_BEQ  = 4'h8,
      ALU_BNE  = 4'h9,
      ALU_BAL  = 4'hA,
      ALU_JAL  = 4'hB,
      ALU_JALR = 4'hC
   } alu_op_e;

   // Issue controller states.
   typedef enum logic [2:0] {
      ST_RUN      = 3'd0,  // normal issue
      ST_DELAY    = 3'd1,  // branch issued, delay slot pending
      ST_REDIRECT = 3'd2,  // one cycle, steer fetch to the branch target
      ST_REFILL   = 3'd3,  // waiting for the first target instruction
      ST_TRAP     = 3'd4   // hold until the handler acknowledges
   } issue_state_e;

endpackage

// File: rtl/alu_issue_ctrl_hazard_detect.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl_hazard_detect
// Combinational load-use hazard compare. The controller registers the
// destination of the last issued load (0 when the last issued op was not a
// load, or was a load to r0); any decoded source that is actually read and
// matches that register needs one bubble.
// Ports:
//   load_wr      in  5 : destination of the load issued last cycle (0 = none)
//   dec_rs/rt    in  5 : decoded source register indices
//   dec_uses_rs  in  1 : rs is read by the decoded op
//   dec_uses_rt  in  1 : rt is read by the decoded op
//   hazard       out 1 : decoded op must wait one cycle
// -----------------------------------------------------------------------------
module alu_issue_ctrl_hazard_detect (
   input  logic [4:0] load_wr,
   input  logic [4:0] dec_rs,
   input  logic [4:0] dec_rt,
   input  logic       dec_uses_rs,
   input  logic       dec_uses_rt,
   output logic       hazard
);

   logic rs_hit;
   logic rt_hit;

   assign rs_hit = dec_uses_rs && (dec_rs == load_wr);
   assign rt_hit = dec_uses_rt && (dec_rt == load_wr);

   // r0 is never written, so a zero destination can never create a dependency.
   assign hazard = (load_wr != 5'd0) && (rs_hit || rt_hit);

endmodule

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
// Issue controller between decode and the ALU execute stage. Each cycle it
// either issues the decoded op or injects a TRAP_STALL bubble, handling
// load-use hazards, branch delay slots, fetch redirects (with the br_trigger
// handshake) and ALU traps.
// Ports:
//   clk, rst           : clock, asynchronous active-low reset
//   dec_valid/ready    : decode handshake (ready == issue)
//   dec_rs/rt, dec_uses_rs/rt, dec_wr_reg, dec_is_load, dec_is_branch
//                      : decoded operand / class information
//   alu_br_enable      : ALU branch taken (registered in the ALU)
//   alu_br_target      : ALU branch target
//   alu_exception      : ALU exception code
//   issue              : ALU consumes the decoded op this cycle
//   issue_exception    : 0 for a real op, TRAP_STALL for a bubble
//   br_trigger         : new fetch stream in flight (REDIRECT..first refill issue)
//   fetch_redirect     : one-cycle redirect pulse, fetch_target = latched target
//   flush              : kill fetch/decode contents (REDIRECT and TRAP)
//   trap_taken         : one-cycle pulse on trap entry
//   trap_code          : code of the latched trap
//   trap_ack           : handler has taken over, release TRAP
// issue/dec_ready/issue_exception are combinational; all else is registered.
// -----------------------------------------------------------------------------
module alu_issue_ctrl
   import alu_issue_ctrl_pkg::*;
#(
   parameter int unsigned      EXC_W      = 8,
   parameter logic [EXC_W-1:0] TRAP_STALL = EXC_W'(TRAP_STALL_CODE),
   parameter logic [EXC_W-1:0] TRAP_SLOT  = EXC_W'(TRAP_SLOT_CODE)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             dec_valid,
   output logic             dec_ready,
   input  logic [4:0]       dec_rs,
   input  logic [4:0]       dec_rt,
   input  logic             dec_uses_rs,
   input  logic             dec_uses_rt,
   input  logic [4:0]       dec_wr_reg,
   input  logic             dec_is_load,
   input  logic             dec_is_branch,
   input  logic             alu_br_enable,
   input  logic [31:0]      alu_br_target,
   input  logic [EXC_W-1:0] alu_exception,
   output logic             issue,
   output logic [EXC_W-1:0] issue_exception,
   output logic             br_trigger,
   output logic             fetch_redirect,
   output logic [31:0]      fetch_target,
   output logic             flush,
   output logic             trap_taken,
   output logic [EXC_W-1:0] trap_code,
   input  logic             trap_ack
);

   issue_state_e     state_q, state_d;
   logic [4:0]       load_wr_q, load_wr_d;
   logic             taken_q, taken_d;
   logic [31:0]      target_q, target_d;
   logic             br_trigger_q, br_trigger_d;
   logic             fetch_redirect_q, fetch_redirect_d;
   logic             flush_q, flush_d;
   logic             trap_taken_q, trap_taken_d;
   logic [EXC_W-1:0] trap_code_q, trap_code_d;

   logic hazard;
   logic issue_state;
   logic slot_branch;
   logic exc_real;
   logic issue_c;

   alu_issue_ctrl_hazard_detect u_hazard_detect (
      .load_wr     (load_wr_q),
      .dec_rs      (dec_rs),
      .dec_rt      (dec_rt),
      .dec_uses_rs (dec_uses_rs),
      .dec_uses_rt (dec_uses_rt),
      .hazard      (hazard)
   );

   // NOTE: every signal written in an always_comb gets a default first, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      issue_state = (state_q == ST_RUN) || (state_q == ST_DELAY) || (state_q == ST_REFILL);
      // A branch that would otherwise issue as the delay slot is refused.
      slot_branch = (state_q == ST_DELAY) && dec_valid && !hazard && dec_is_branch;
      // TRAP_STALL on the ALU bus is just a bubble echoing back, not a fault.
      exc_real    = (alu_exception != '0) && (alu_exception != TRAP_STALL) &&
                    (state_q != ST_TRAP);
      // Gated by rst so the combinational outputs also show reset values
      // while reset is held.
      issue_c     = rst && issue_state && dec_valid && !hazard && !flush_q &&
                    !((state_q == ST_DELAY) && dec_is_branch);

      state_d     = state_q;
      taken_d     = taken_q;
      target_d    = target_q;
      trap_code_d = trap_code_q;

      // Branch outcome may arrive before the delay slot is available.
      if ((state_q == ST_DELAY) && alu_br_enable) begin
         taken_d  = 1'b1;
         target_d = alu_br_target;
      end

      if (exc_real) begin
         state_d     = ST_TRAP;
         trap_code_d = alu_exception;
         taken_d     = 1'b0;
      end else if (slot_branch) begin
         state_d     = ST_TRAP;
         trap_code_d = TRAP_SLOT;
         taken_d     = 1'b0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (issue_c && dec_is_branch) state_d = ST_DELAY;
            end
            ST_DELAY: begin
               if (issue_c) begin
                  // The outcome can be visible in the same cycle the slot issues.
                  state_d = (taken_q || alu_br_enable) ? ST_REDIRECT : ST_RUN;
                  taken_d = 1'b0;
               end
            end
            ST_REDIRECT: state_d = ST_REFILL;
            ST_REFILL: begin
               if (issue_c) state_d = dec_is_branch ? ST_DELAY : ST_RUN;
            end
            ST_TRAP: begin
               if (trap_ack) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
         endcase
      end

      // Load tracking lives for exactly one cycle after the load issues.
      load_wr_d = (issue_c && dec_is_load) ? dec_wr_reg : 5'd0;

      // Registered outputs are decoded from the next state so they line up
      // with the state they describe.
      fetch_redirect_d = (state_d == ST_REDIRECT);
      flush_d          = (state_d == ST_REDIRECT) || (state_d == ST_TRAP);
      br_trigger_d     = (state_d == ST_REDIRECT) || (state_d == ST_REFILL);
      trap_taken_d     = (state_d == ST_TRAP) && (state_q != ST_TRAP);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q          <= ST_RUN;
         load_wr_q        <= 5'd0;
         taken_q          <= 1'b0;
         target_q         <= 32'd0;
         br_trigger_q     <= 1'b0;
         fetch_redirect_q <= 1'b0;
         flush_q          <= 1'b0;
         trap_taken_q     <= 1'b0;
         trap_code_q      <= '0;
      end else begin
         state_q          <= state_d;
         load_wr_q        <= load_wr_d;
         taken_q          <= taken_d;
         target_q         <= target_d;
         br_trigger_q     <= br_trigger_d;
         fetch_redirect_q <= fetch_redirect_d;
         flush_q          <= flush_d;
         trap_taken_q     <= trap_taken_d;
         trap_code_q      <= trap_code_d;
      end
   end

   assign issue           = issue_c;
   assign dec_ready       = issue_c;
   assign issue_exception = issue_c ? '0 : TRAP_STALL;
   assign br_trigger      = br_trigger_q;
   assign fetch_redirect  = fetch_redirect_q;
   assign fetch_target    = target_q;
   assign flush           = flush_q;
   assign trap_taken      = trap_taken_q;
   assign trap_code       = trap_code_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_ctrl
// Directed scenarios followed by randomized traffic for alu_issue_ctrl. Every
// cycle is compared against a behavioural model built from the controller's
// rules (pending-slot / redirect / refill / trap flags and a one-cycle load
// destination), plus constant anchor checks at the key points of each scenario.
// -----------------------------------------------------------------------------
module tb_alu_issue_ctrl;
   import alu_issue_ctrl_pkg::*;

   localparam int         EXC_W = 8;
   localparam logic [7:0] STALL = TRAP_STALL_CODE;
   localparam logic [7:0] SLOT  = TRAP_SLOT_CODE;
   localparam logic [7:0] OVF   = TRAP_OVERFLOW;
   localparam logic [7:0] ILL   = TRAP_ILLEGAL;

   logic             clk;
   logic             rst;
   logic             dec_valid;
   logic             dec_ready;
   logic [4:0]       dec_rs, dec_rt, dec_wr_reg;
   logic             dec_uses_rs, dec_uses_rt, dec_is_load, dec_is_branch;
   logic             alu_br_enable;
   logic [31:0]      alu_br_target;
   logic [EXC_W-1:0] alu_exception;
   logic             issue;
   logic [EXC_W-1:0] issue_exception;
   logic             br_trigger, fetch_redirect, flush, trap_taken, trap_ack;
   logic [31:0]      fetch_target;
   logic [EXC_W-1:0] trap_code;

   alu_issue_ctrl #(.EXC_W(EXC_W), .TRAP_STALL(STALL), .TRAP_SLOT(SLOT)) dut (
      .clk             (clk),
      .rst             (rst),
      .dec_valid       (dec_valid),
      .dec_ready       (dec_ready),
      .dec_rs          (dec_rs),
      .dec_rt          (dec_rt),
      .dec_uses_rs     (dec_uses_rs),
      .dec_uses_rt     (dec_uses_rt),
      .dec_wr_reg      (dec_wr_reg),
      .dec_is_load     (dec_is_load),
      .dec_is_branch   (dec_is_branch),
      .alu_br_enable   (alu_br_enable),
      .alu_br_target   (alu_br_target),
      .alu_exception   (alu_exception),
      .issue           (issue),
      .issue_exception (issue_exception),
      .br_trigger      (br_trigger),
      .fetch_redirect  (fetch_redirect),
      .fetch_target    (fetch_target),
      .flush           (flush),
      .trap_taken      (trap_taken),
      .trap_code       (trap_code),
      .trap_ack        (trap_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Behavioural model state.
   bit         m_slot_pending;  // branch issued, delay slot not yet issued
   bit         m_br_taken;      // branch outcome already seen as taken
   bit         m_redirect;      // this cycle is the redirect cycle
   bit         m_refill;        // waiting for the first target instruction
   bit         m_in_trap;
   bit         m_trap_pulse;
   logic [7:0] m_trap_code;
   logic [31:0] m_target;
   logic [4:0] m_load_dest;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   function automatic bit m_hazard();
      return (m_load_dest != 5'd0) &&
             ((dec_uses_rs && dec_rs == m_load_dest) || (dec_uses_rt && dec_rt == m_load_dest));
   endfunction

   function automatic bit m_issue();
      return rst && dec_valid && !m_hazard() && !m_in_trap && !m_redirect &&
             !(m_slot_pending && dec_is_branch);
   endfunction

   task automatic model_reset();
      m_slot_pending = 0; m_br_taken = 0; m_redirect = 0; m_refill = 0;
      m_in_trap = 0; m_trap_pulse = 0; m_trap_code = 8'h00; m_target = 32'h0;
      m_load_dest = 5'd0;
   endtask

   task automatic model_advance();
      bit iss, taken_now, exc, slot_trap;
      iss       = m_issue();
      taken_now = m_br_taken || (m_slot_pending && alu_br_enable);
      exc       = (alu_exception != 8'h00) && (alu_exception != STALL) && !m_in_trap;
      slot_trap = m_slot_pending && dec_valid && !m_hazard() && dec_is_branch;
      if (m_slot_pending && alu_br_enable) m_target = alu_br_target;
      m_load_dest  = (iss && dec_is_load) ? dec_wr_reg : 5'd0;
      m_trap_pulse = 0;
      if (exc || slot_trap) begin
         m_in_trap = 1; m_trap_pulse = 1; m_trap_code = exc ? alu_exception : SLOT;
         m_slot_pending = 0; m_br_taken = 0; m_redirect = 0; m_refill = 0;
      end else if (m_in_trap) begin
         if (trap_ack) m_in_trap = 0;
      end else if (m_redirect) begin
         m_redirect = 0; m_refill = 1;
      end else if (iss) begin
         if (m_slot_pending) begin
            m_slot_pending = 0; m_br_taken = 0; m_redirect = taken_now;
         end else begin
            m_refill = 0;
            if (dec_is_branch) m_slot_pending = 1;
         end
      end else begin
         m_br_taken = taken_now;
      end
   endtask

   // Compare every output against the model at the falling edge.
   task automatic sample(input string tag);
      bit e_iss;
      @(negedge clk);
      e_iss = m_issue();
      check({tag, ".issue"},      32'(issue),           32'(e_iss));
      check({tag, ".dec_ready"},  32'(dec_ready),       32'(e_iss));
      check({tag, ".issue_exc"},  32'(issue_exception), e_iss ? 32'h0 : 32'(STALL));
      check({tag, ".br_trigger"}, 32'(br_trigger),      32'(m_redirect || m_refill));
      check({tag, ".redirect"},   32'(fetch_redirect),  32'(m_redirect));
      check({tag, ".target"},     fetch_target,         m_target);
      check({tag, ".flush"},      32'(flush),           32'(m_redirect || m_in_trap));
      check({tag, ".trap_taken"}, 32'(trap_taken),      32'(m_trap_pulse));
      check({tag, ".trap_code"},  32'(trap_code),       32'(m_trap_code));
   endtask

   task automatic tick();
      model_advance();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input string tag);
      sample(tag);
      tick();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".issue"},      32'(issue),           32'h0);
      check({tag, ".dec_ready"},  32'(dec_ready),       32'h0);
      check({tag, ".issue_exc"},  32'(issue_exception), 32'(STALL));
      check({tag, ".br_trigger"}, 32'(br_trigger),      32'h0);
      check({tag, ".redirect"},   32'(fetch_redirect),  32'h0);
      check({tag, ".target"},     fetch_target,         32'h0);
      check({tag, ".flush"},      32'(flush),           32'h0);
      check({tag, ".trap_taken"}, 32'(trap_taken),      32'h0);
      check({tag, ".trap_code"},  32'(trap_code),       32'h0);
   endtask

   task automatic set_idle();
      dec_valid = 0; dec_rs = 0; dec_rt = 0; dec_uses_rs = 0; dec_uses_rt = 0;
      dec_wr_reg = 0; dec_is_load = 0; dec_is_branch = 0;
      alu_br_enable = 0; alu_br_target = 0; alu_exception = 0; trap_ack = 0;
   endtask

   task automatic set_op(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wr,
                         input logic ld, input logic br);
      dec_valid = 1; dec_rs = rs; dec_rt = rt; dec_uses_rs = 1; dec_uses_rt = 1;
      dec_wr_reg = wr; dec_is_load = ld; dec_is_branch = br;
   endtask

   // Safety net against a stuck simulation.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      set_idle();
      model_reset();
      rst = 0;
      dec_valid = 1;  // reset must mask issue even with a valid op
      #3;
      check_reset_outputs("reset");
      @(posedge clk); @(posedge clk); #1;
      rst = 1;
      set_idle();

      // Back-to-back ALU_ADD: issue every cycle, no bubbles.
      set_op(5'd1, 5'd2, 5'd3, 0, 0);
      for (int i = 0; i < 4; i++) begin
         sample("add");
         check("add.anchor_issue", 32'(issue), 32'h1);
         check("add.anchor_exc", 32'(issue_exception), 32'h0);
         tick();
      end

      // Load r5 then rs=5: exactly one bubble.
      set_op(5'd1, 5'd2, 5'd5, 1, 0); cyc("ld5");
      set_op(5'd5, 5'd2, 5'd6, 0, 0);
      sample("use5_hold");
      check("use5.anchor_bubble", 32'(issue_exception), 32'(STALL));
      tick();
      sample("use5_go");
      check("use5.anchor_issue", 32'(issue), 32'h1);
      tick();
      // Load r5 then rs=0: no bubble.
      set_op(5'd1, 5'd2, 5'd5, 1, 0); cyc("ld5b");
      set_op(5'd0, 5'd2, 5'd6, 0, 0);
      sample("use0");
      check("use0.anchor_issue", 32'(issue), 32'h1);
      tick();
      // Load to r0 then rs=0: no bubble.
      set_op(5'd1, 5'd2, 5'd0, 1, 0); cyc("ld0");
      set_op(5'd0, 5'd0, 5'd6, 0, 0);
      sample("ld0_use");
      check("ld0.anchor_issue", 32'(issue), 32'h1);
      tick();

      // BEQ taken to 0x100.
      set_op(5'd1, 5'd2, 5'd0, 0, 1); cyc("beq");
      set_op(5'd3, 5'd4, 5'd7, 0, 0);
      alu_br_enable = 1; alu_br_target = 32'h100;
      cyc("beq_slot");
      alu_br_enable = 0; alu_br_target = 32'h0;
      sample("beq_redir");
      check("beq.anchor_redirect", 32'(fetch_redirect), 32'h1);
      check("beq.anchor_target", fetch_target, 32'h100);
      check("beq.anchor_flush", 32'(flush), 32'h1);
      check("beq.anchor_issue", 32'(issue), 32'h0);
      tick();
      dec_valid = 0;
      sample("beq_refill_wait");
      check("beq.anchor_trig_hold", 32'(br_trigger), 32'h1);
      tick();
      dec_valid = 1;
      cyc("beq_refill_issue");
      sample("beq_after");
      check("beq.anchor_trig_drop", 32'(br_trigger), 32'h0);
      tick();

      // BNE not taken, slot arrives one cycle late.
      set_op(5'd1, 5'd2, 5'd0, 0, 1); cyc("bne");
      dec_valid = 0; dec_is_branch = 0; cyc("bne_wait");
      set_op(5'd3, 5'd4, 5'd7, 0, 0); cyc("bne_slot");
      sample("bne_after");
      check("bne.anchor_redirect", 32'(fetch_redirect), 32'h0);
      check("bne.anchor_trig", 32'(br_trigger), 32'h0);
      check("bne.anchor_issue", 32'(issue), 32'h1);
      tick();

      // TRAP_STALL echoed by the ALU is not a trap.
      alu_exception = STALL; cyc("stall_echo");
      alu_exception = 0;
      sample("stall_echo_after");
      check("stall_echo.anchor_no_trap", 32'(trap_taken), 32'h0);
      tick();

      // Overflow trap.
      alu_exception = OVF; cyc("ovf");
      alu_exception = 0;
      sample("ovf_taken");
      check("ovf.anchor_pulse", 32'(trap_taken), 32'h1);
      check("ovf.anchor_code", 32'(trap_code), 32'(OVF));
      check("ovf.anchor_no_issue", 32'(issue), 32'h0);
      tick();
      alu_exception = ILL; cyc("ovf_ignore");
      alu_exception = 0; trap_ack = 1;
      sample("ovf_ack");
      check("ovf.anchor_code_held", 32'(trap_code), 32'(OVF));
      tick();
      trap_ack = 0;
      sample("ovf_resume");
      check("ovf.anchor_resume", 32'(issue), 32'h1);
      tick();

      // Branch in a delay slot.
      set_op(5'd1, 5'd2, 5'd0, 0, 1); cyc("slotbr");
      sample("slotbr_refused");
      check("slotbr.anchor_bubble", 32'(issue), 32'h0);
      tick();
      set_idle();
      sample("slotbr_trap");
      check("slotbr.anchor_code", 32'(trap_code), 32'(SLOT));
      check("slotbr.anchor_pulse", 32'(trap_taken), 32'h1);
      tick();
      trap_ack = 1; cyc("slotbr_ack");
      trap_ack = 0;

      // Reset asserted mid-DELAY with a taken outcome already latched.
      set_op(5'd1, 5'd2, 5'd0, 0, 1); cyc("rstbr");
      set_idle(); alu_br_enable = 1; alu_br_target = 32'h200; cyc("rstbr_taken");
      set_op(5'd3, 5'd4, 5'd7, 0, 0);
      alu_br_enable = 0;
      #2;
      rst = 0;
      #1;
      check_reset_outputs("rst_mid_delay");
      model_reset();
      @(posedge clk); #1;
      rst = 1;
      cyc("rst_resume");
      sample("rst_resume_after");
      check("rst.anchor_no_redirect", 32'(fetch_redirect), 32'h0);
      tick();

      // Randomized traffic.
      for (int i = 0; i < 500; i++) begin
         dec_valid     = ($urandom_range(0, 3) != 0);
         dec_rs        = 5'($urandom_range(0, 7));
         dec_rt        = 5'($urandom_range(0, 7));
         dec_uses_rs   = 1'($urandom_range(0, 1));
         dec_uses_rt   = 1'($urandom_range(0, 1));
         dec_wr_reg    = 5'($urandom_range(0, 7));
         dec_is_load   = ($urandom_range(0, 3) == 0);
         dec_is_branch = ($urandom_range(0, 6) == 0);
         alu_br_enable = 1'($urandom_range(0, 1));
         alu_br_target = $urandom;
         r = int'($urandom_range(0, 99));
         alu_exception = (r < 3) ? OVF : (r < 6) ? STALL : (r < 7) ? ILL : 8'h00;
         trap_ack      = ($urandom_range(0, 2) == 0);
         cyc("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
